// File: rtl/imul_iter_32b_if.sv
// Operand/product stream bundle for the iterative 32-bit multiplier.
// master = operand producer / product consumer, slave = multiplier.
interface imul_iter_32b_if;
  logic        istream_val;
  logic        istream_rdy;
  logic [31:0] in0;
  logic [31:0] in1;
  logic        ostream_val;
  logic        ostream_rdy;
  logic [31:0] out;

  modport master (
    output istream_val, in0, in1, ostream_rdy,
    input  istream_rdy, ostream_val, out
  );

  modport slave (
    input  istream_val, in0, in1, ostream_rdy,
    output istream_rdy, ostream_val, out
  );
endinterface

// File: rtl/imul_iter_32b.sv
// Iterative shift-add 32x32 multiplier returning the low 32 product bits.
// Fixed 32-cycle CALC phase, Moore handshakes on both streams.
module imul_iter_32b (
  input logic           clk,
  input logic           reset,
  imul_iter_32b_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] acc;
  logic [4:0]  cnt;
  logic        istream_rdy_q;
  logic        ostream_val_q;

  // Handshake flags are registered alongside state so they always match it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      a             <= '0;
      b             <= '0;
      acc           <= '0;
      cnt           <= '0;
      istream_rdy_q <= 1'b1;
      ostream_val_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.istream_val) begin
            a             <= bus.in0;
            b             <= bus.in1;
            acc           <= '0;
            cnt           <= '0;
            state         <= CALC;
            istream_rdy_q <= 1'b0;
          end
        end
        CALC: begin
          if (b[0]) acc <= acc + a;
          a   <= {a[30:0], 1'b0};
          b   <= {1'b0, b[31:1]};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state         <= DONE;
            ostream_val_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.ostream_rdy) begin
            state         <= IDLE;
            ostream_val_q <= 1'b0;
            istream_rdy_q <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          istream_rdy_q <= 1'b1;
          ostream_val_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.istream_rdy = istream_rdy_q;
  assign bus.ostream_val = ostream_val_q;
  assign bus.out         = acc;

endmodule

// File: doc/imul_iter_32b.md
IMUL_ITER_32B -- requirements
Module: imul_iter_32b

Interface
REQ-001 Parameters: none; all widths fixed at 32 bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 istream_val  input  1  operand pair valid.
REQ-005 istream_rdy  output  1  unit can accept operands.
REQ-006 in0  input  32  multiplicand.
REQ-007 in1  input  32  multiplier.
REQ-008 ostream_val  output  1  product valid.
REQ-009 ostream_rdy  input  1  consumer can accept product.
REQ-010 out  output  32  product, low 32 bits of in0*in1.

Function
REQ-011 FSM states SHALL be exactly IDLE, CALC, DONE.
REQ-012 istream_rdy SHALL be 1 only in IDLE; ostream_val SHALL be 1 only in DONE; both decoded from state only (Moore).
REQ-013 Input transfer SHALL occur on an edge with state IDLE and istream_val=1: load a=in0, b=in1, acc=0, cnt=0; next state CALC.
REQ-014 IDLE with istream_val=0 SHALL stay IDLE with all datapath registers unchanged.
REQ-015 Each CALC edge: if b[0]=1 then acc=acc+a (mod 2^32); a=a<<1 (zero fill); b=b>>1 (logical, zero fill); cnt=cnt+1.
REQ-016 CALC SHALL last exactly 32 cycles regardless of operand values (no early exit); on the edge where cnt=31, next state DONE.
REQ-017 Latency: ostream_val SHALL rise in the 33rd cycle after the input-transfer edge's cycle (32 CALC cycles, then DONE).
REQ-018 out SHALL equal acc; stable and unchanged throughout DONE.
REQ-019 Output transfer SHALL occur on an edge with state DONE and ostream_rdy=1; next state IDLE; no direct DONE->CALC path.
REQ-020 DONE with ostream_rdy=0 SHALL hold state and out indefinitely (backpressure).
REQ-021 istream_val, in0, in1 SHALL be ignored outside IDLE; ostream_rdy SHALL be ignored outside DONE.
REQ-022 Arithmetic is unsigned shift-add; result equals low 32 bits of product and is identical for two's-complement signed operands.
REQ-023 Overflow of acc or a SHALL wrap silently; no status output.
REQ-024 Throughput: max one product per 34 cycles (1 IDLE + 32 CALC + 1 DONE) with both sides always ready.

Reset
REQ-025 Edge with reset=1 SHALL force state=IDLE, acc=0, a=0, b=0, cnt=0, overriding all other inputs, in any state.
REQ-026 After reset edge: istream_rdy=1, ostream_val=0, out=0.
REQ-027 Reset mid-CALC or in DONE SHALL discard the operation; no ostream_val pulse follows.
REQ-028 istream_val=1 on an edge with reset=1 SHALL NOT be accepted.

Verification
REQ-029 Basic: reset, then in0=3, in1=4, istream_val=1 one cycle -> istream_rdy=0 for 33 cycles, ostream_val=1 on 33rd cycle after transfer, out=12; ostream_rdy=1 -> IDLE next cycle.
REQ-030 Wrap/signed: in0=0xFFFFFFFF, in1=0xFFFFFFFF -> out=0x00000001; in0=0xFFFFFFFF, in1=2 -> out=0xFFFFFFFE; in0=0x80000000, in1=2 -> out=0.
REQ-031 Zero/identity: 0x12345678*0 -> 0; 0x12345678*1 -> 0x12345678; latency still 32 CALC cycles each.
REQ-032 Backpressure: product 7*6, ostream_rdy=0 for 5 DONE cycles -> ostream_val=1 and out=42 held all 5, istream_rdy=0; rdy=1 -> IDLE.
REQ-033 Ignored input: during CALC of 5*5 drive istream_val=1, in0=9, in1=9 -> out=25, no second product.
REQ-034 Reset mid-op: start 100*100, reset at CALC cycle 10 -> ostream_val=0, istream_rdy=1 next cycle; then 2*3 -> out=6.
